lu_log2: RTL and testbench

- Fixed-point base-2 logarithm unit; the inverse of the GELU exponent unit (EU).
- Takes a positive Q5.26 operand x and returns log2(x) in Q5.26. Method: leading-one detection gives the integer part; chord interpolation over 8 segments of log2(1+f) gives the fractional part. The segment table is internal.
- Sits beside EU in the GELU/softmax datapath.
- 3-stage pipeline, one result per cycle, valid/ready handshake on both sides.

---
 rtl/lu_log2.sv | 152 +++++++++++++++
 tb/tb_lu_log2.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_log2.sv
// Fixed-point base-2 logarithm: Q5.26 in, Q5.26 out, four register levels.
// Leading-one detection supplies the integer part; an 8-segment chord of log2(1+f) supplies the fraction.
`timescale 1ns/1ps

module lu_log2 #(
  parameter int W        = 32,
  parameter int Q        = 26,
  parameter int SEG_BITS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  output logic         ready_in,
  input  logic [W-1:0] x_in,
  output logic         valid_out,
  input  logic         ready_out,
  output logic [W-1:0] log_result,
  output logic         err_out
);

  localparam int PW  = $clog2(W-1);
  localparam int IPW = PW + 2;
  localparam logic [W-1:0] ERR_VALUE = {1'b1, {(W-1){1'b0}}};

  logic advance;

  logic          v1, s1_err;
  logic [W-1:0]  s1_x;
  logic [PW-1:0] s1_p;

  logic                  v2, s2_err;
  logic [Q-1:0]          s2_f;
  logic signed [IPW-1:0] s2_ip;
  logic [W-1:0]          s2_k, s2_b;

  logic                  v3, s3_err;
  logic [W-1:0]          s3_frac;
  logic signed [IPW-1:0] s3_ip;

  // One stalled output freezes the whole pipe, so ready_in is just the advance term.
  assign advance  = !(valid_out && !ready_out);
  assign ready_in = advance;

  logic [PW-1:0] lead_pos;
  logic          x_nonpos;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < W-1; i++) begin
      if (x_in[i]) lead_pos = PW'(i);
    end
  end

  assign x_nonpos = x_in[W-1] || (x_in == '0);

  logic [PW:0]           shamt;
  logic [W-1:0]          norm;
  logic [Q-1:0]          frac_bits;
  logic [SEG_BITS-1:0]   seg;
  logic signed [IPW-1:0] int_part;
  logic [W-1:0]          seg_k, seg_b;

  assign shamt     = (PW+1)'(W-1) - {1'b0, s1_p};
  assign norm      = s1_x << shamt;
  assign frac_bits = norm[W-2 -: Q];
  assign seg       = frac_bits[Q-1 -: SEG_BITS];
  assign int_part  = IPW'({{(IPW-PW){1'b0}}, s1_p}) - IPW'(Q);

  // Chord slope and intercept of log2(1+t) over [s/8, (s+1)/8], Q26; b[0] = 0 keeps powers of two exact.
  always_comb begin
    seg_k = '0;
    seg_b = '0;
    case (seg)
      3'd0: begin seg_k = W'(91227790); seg_b = W'(0);        end
      3'd1: begin seg_k = W'(81606039); seg_b = W'(1202719);  end
      3'd2: begin seg_k = W'(73821642); seg_b = W'(3148818);  end
      3'd3: begin seg_k = W'(67393879); seg_b = W'(5559229);  end
      3'd4: begin seg_k = W'(61996359); seg_b = W'(8257989);  end
      3'd5: begin seg_k = W'(57399663); seg_b = W'(11130924); end
      3'd6: begin seg_k = W'(53437808); seg_b = W'(14102316); end
      default: begin seg_k = W'(49987731); seg_b = W'(17121133); end
    endcase
  end

  logic signed [2*W-1:0] k_ext, f_ext, prod, prod_sh;
  logic [W-1:0]          frac_sum;

  assign k_ext    = {{W{s2_k[W-1]}}, s2_k};
  assign f_ext    = {{(2*W-Q){1'b0}}, s2_f};
  assign prod     = k_ext * f_ext;
  assign prod_sh  = prod >>> Q;
  assign frac_sum = prod_sh[W-1:0] + s2_b;

  logic [W-1:0] ip_ext, result_sum;

  assign ip_ext     = {{(W-IPW){s3_ip[IPW-1]}}, s3_ip};
  assign result_sum = (ip_ext << Q) + s3_frac;

  // The leading one, the zero fill below the fraction and the product's high word carry no information.
  logic unused_bits;
  assign unused_bits = ^{prod_sh[2*W-1:W], norm[W-1], norm[W-2-Q:0]};

  // Data registers only load on a valid beat so the outputs keep their last result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      s1_err     <= 1'b0;
      s1_x       <= '0;
      s1_p       <= '0;
      v2         <= 1'b0;
      s2_err     <= 1'b0;
      s2_f       <= '0;
      s2_ip      <= '0;
      s2_k       <= '0;
      s2_b       <= '0;
      v3         <= 1'b0;
      s3_err     <= 1'b0;
      s3_frac    <= '0;
      s3_ip      <= '0;
      valid_out  <= 1'b0;
      err_out    <= 1'b0;
      log_result <= '0;
    end else if (advance) begin
      v1 <= valid_in;
      if (valid_in) begin
        s1_x   <= x_in;
        s1_err <= x_nonpos;
        s1_p   <= lead_pos;
      end
      v2 <= v1;
      if (v1) begin
        s2_f   <= frac_bits;
        s2_ip  <= int_part;
        s2_k   <= seg_k;
        s2_b   <= seg_b;
        s2_err <= s1_err;
      end
      v3 <= v2;
      if (v2) begin
        s3_frac <= frac_sum;
        s3_ip   <= s2_ip;
        s3_err  <= s2_err;
      end
      valid_out <= v3;
      if (v3) begin
        err_out    <= s3_err;
        log_result <= s3_err ? ERR_VALUE : result_sum;
      end
    end
  end

endmodule

// File: tb/tb_lu_log2.sv
// Directed and randomized checks of lu_log2 results, latency, error flagging, backpressure and reset.
`timescale 1ns/1ps

module tb_lu_log2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [31:0] x_in = '0;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic [31:0] log_result;
  logic        err_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] res_q[$];
  logic        err_q[$];
  int          out_cyc_q[$];
  int          acc_cyc_q[$];

  lu_log2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .x_in       (x_in),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .log_result (log_result),
    .err_out    (err_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are recorded half a cycle before the edge that performs them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_in && ready_in) acc_cyc_q.push_back(cyc + 1);
      if (valid_out && ready_out) begin
        res_q.push_back(log_result);
        err_q.push_back(err_out);
        out_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic real log2_ref(input logic [31:0] x);
    return $ln(real'(x)) / $ln(2.0) - 26.0;
  endfunction

  function automatic real q2r(input logic [31:0] r);
    return real'($signed(r)) / 67108864.0;
  endfunction

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_q();
    res_q.delete();
    err_q.delete();
    out_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  task automatic push(input logic [31:0] x);
    int guard = 0;
    valid_in = 1'b1;
    x_in = x;
    @(negedge clk);
    while (!ready_in && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_in) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout ready_in=%0b after %0d cycles, need 1", ready_in, guard);
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_results(input int n, input string tag);
    int guard = 0;
    while (res_q.size() < n && guard < 300) begin
      tick();
      guard++;
    end
    if (res_q.size() < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_count got %0d results, need %0d", tag, res_q.size(), n);
    end
  endtask

  task automatic test_reset();
    valid_in = 1'b0;
    ready_out = 1'b1;
    #12;
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_out got %b need 0", valid_out); end
    checks++;
    if (log_result !== 32'h0) begin errors++; $display("[TB] FAIL reset_log_result got %h need 0", log_result); end
    checks++;
    if (err_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_out got %b need 0", err_out); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_in got %b need 1", ready_in); end
    tick();
  endtask

  task automatic test_powers();
    logic [31:0] vec[4] = '{32'h04000000, 32'h08000000, 32'h02000000, 32'h7C000000};
    logic [31:0] exp_r[3] = '{32'h00000000, 32'h04000000, 32'hFC000000};
    clear_q();
    ready_out = 1'b1;
    foreach (vec[i]) push(vec[i]);
    idle(0);
    wait_results(4, "powers");
    if (res_q.size() >= 4 && acc_cyc_q.size() >= 4) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (res_q[i] !== exp_r[i]) begin
          errors++;
          $display("[TB] FAIL powers_value[%0d] x=%h got %h need %h", i, vec[i], res_q[i], exp_r[i]);
        end
      end
      checks++;
      if (absr(q2r(res_q[3]) - log2_ref(vec[3])) > 0.003) begin
        errors++;
        $display("[TB] FAIL powers_31 got %f need %f +-0.003", q2r(res_q[3]), log2_ref(vec[3]));
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (err_q[i] !== 1'b0) begin errors++; $display("[TB] FAIL powers_err[%0d] got %b need 0", i, err_q[i]); end
        checks++;
        if (out_cyc_q[i] - acc_cyc_q[i] != 3) begin
          errors++;
          $display("[TB] FAIL powers_latency[%0d] got %0d need 3", i, out_cyc_q[i] - acc_cyc_q[i]);
        end
      end
    end
  endtask

  task automatic test_segments();
    logic [31:0] vec[9];
    longint exp_i, got_i;
    for (int s = 0; s < 8; s++) begin
      logic [31:0] base;
      base = (32'd8 + 32'(s)) << 23;
      case (s % 3)
        0: vec[s] = base >> 1;
        1: vec[s] = base;
        default: vec[s] = base << 1;
      endcase
    end
    vec[8] = 32'h0C000000;
    clear_q();
    ready_out = 1'b1;
    foreach (vec[i]) push(vec[i]);
    wait_results(9, "segments");
    if (res_q.size() >= 9) begin
      for (int i = 0; i < 8; i++) begin
        exp_i = longint'(log2_ref(vec[i]) * 67108864.0);
        got_i = longint'($signed(res_q[i]));
        checks++;
        if (got_i - exp_i > 4 || exp_i - got_i > 4) begin
          errors++;
          $display("[TB] FAIL segment_start[%0d] x=%h got %0d need %0d +-4", i, vec[i], got_i, exp_i);
        end
      end
      got_i = longint'($signed(res_q[8]));
      checks++;
      if (got_i - 64'sh06570069 > 4 || 64'sh06570069 - got_i > 4) begin
        errors++;
        $display("[TB] FAIL log2_of_3 got %h need 06570069 +-4", res_q[8]);
      end
    end
  endtask

  task automatic test_edges_errors();
    logic [31:0] vec[7] = '{32'h00000001, 32'h7FFFFFFF, 32'h04000000, 32'h00000000,
                            32'h08000000, 32'hFC000000, 32'h02000000};
    logic [31:0] exp_r[7] = '{32'h98000000, 32'h0, 32'h00000000, 32'h80000000,
                              32'h04000000, 32'h80000000, 32'hFC000000};
    logic exp_e[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    clear_q();
    ready_out = 1'b1;
    foreach (vec[i]) push(vec[i]);
    wait_results(7, "edges");
    if (res_q.size() >= 7) begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (i == 1) begin
          if (absr(q2r(res_q[i]) - log2_ref(vec[i])) > 0.003) begin
            errors++;
            $display("[TB] FAIL edge_max got %f need %f +-0.003", q2r(res_q[i]), log2_ref(vec[i]));
          end
        end else if (res_q[i] !== exp_r[i]) begin
          errors++;
          $display("[TB] FAIL edge_value[%0d] x=%h got %h need %h", i, vec[i], res_q[i], exp_r[i]);
        end
        checks++;
        if (err_q[i] !== exp_e[i]) begin
          errors++;
          $display("[TB] FAIL edge_err[%0d] x=%h got %b need %b", i, vec[i], err_q[i], exp_e[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec[10];
    logic [31:0] held;
    logic stalled_prev = 1'b0;
    logic accepted;
    int idx = 0;
    for (int i = 0; i < 10; i++) vec[i] = (32'h00500000 + 32'(i) * 32'h00123457) << (i % 3);
    clear_q();
    held = '0;
    for (int c = 0; c < 60 && (idx < 10 || res_q.size() < 10); c++) begin
      ready_out = !(c >= 4 && c <= 7);
      valid_in = (idx < 10);
      x_in = (idx < 10) ? vec[idx] : 32'h0;
      @(negedge clk);
      if (stalled_prev) begin
        checks++;
        if (log_result !== held || valid_out !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stall_hold got %h/%b need %h/1", log_result, valid_out, held);
        end
      end
      if (valid_out && !ready_out) begin
        checks++;
        if (ready_in !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready_in got %b need 0", ready_in); end
      end
      stalled_prev = valid_out && !ready_out;
      held = log_result;
      accepted = valid_in && ready_in;
      tick();
      if (accepted) idx++;
    end
    ready_out = 1'b1;
    idle(0);
    wait_results(10, "b2b");
    idle(6);
    checks++;
    if (res_q.size() != 10) begin
      errors++;
      $display("[TB] FAIL b2b_total got %0d results need 10", res_q.size());
    end
    for (int i = 0; i < 10 && i < res_q.size(); i++) begin
      checks++;
      if (absr(q2r(res_q[i]) - log2_ref(vec[i])) > 0.003 || err_q[i] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_order[%0d] got %f need %f", i, q2r(res_q[i]), log2_ref(vec[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] xs[$];
    bit drv_done = 1'b0;
    clear_q();
    fork
      begin
        for (int i = 0; i < 5000; i++) begin
          logic [31:0] x;
          x = ($urandom() & 32'h7FFFFFFF) >> ($urandom() % 31);
          if (x == 0) x = 32'h1;
          xs.push_back(x);
          push(x);
          if ($urandom() % 4 == 0) idle($urandom() % 3);
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          ready_out = ($urandom() % 4 != 0);
          tick();
        end
      end
    join
    ready_out = 1'b1;
    wait_results(5000, "random");
    for (int i = 0; i < 5000 && i < res_q.size(); i++) begin
      checks++;
      if (absr(q2r(res_q[i]) - log2_ref(xs[i])) > 0.003 || err_q[i] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random[%0d] x=%h got %f err=%b need %f err=0",
                 i, xs[i], q2r(res_q[i]), err_q[i], log2_ref(xs[i]));
      end
    end
  endtask

  task automatic test_reset_midstream();
    clear_q();
    ready_out = 1'b1;
    push(32'h04000000);
    push(32'h08000000);
    push(32'h0C000000);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got %b need 0", valid_out); end
    checks++;
    if (log_result !== 32'h0) begin errors++; $display("[TB] FAIL midreset_result got %h need 0", log_result); end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    clear_q();
    idle(6);
    checks++;
    if (res_q.size() != 0 || valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_spurious got %0d results valid_out=%b need 0/0", res_q.size(), valid_out);
    end
    push(32'h08000000);
    wait_results(1, "midreset");
    if (res_q.size() >= 1 && acc_cyc_q.size() >= 1) begin
      checks++;
      if (res_q[0] !== 32'h04000000) begin
        errors++;
        $display("[TB] FAIL midreset_new got %h need 04000000", res_q[0]);
      end
      checks++;
      if (out_cyc_q[0] - acc_cyc_q[0] != 3) begin
        errors++;
        $display("[TB] FAIL midreset_latency got %0d need 3", out_cyc_q[0] - acc_cyc_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_powers();
    test_segments();
    test_edges_errors();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
